// File: rtl/inst_fetch_q.sv
// Instruction fetch queue with a program-load mode.
// LOAD fills the instruction memory sequentially. RUN fetches one word per
// cycle from the asynchronous-read memory into a small in-order queue.
// The queue is flushed and refetched on a redirect or a mispredict.
module inst_fetch_q #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int Q_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         load_start,
    input  logic                         load_valid,
    input  logic [INST_WIDTH-1:0]        load_data,
    input  logic                         load_done,
    input  logic                         redirect_valid,
    input  logic [ADDR_WIDTH-1:0]        redirect_addr,
    input  logic                         mispredict,
    input  logic [ADDR_WIDTH-1:0]        mispredict_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INST_WIDTH-1:0]        out_inst,
    output logic [ADDR_WIDTH-1:0]        out_pc,
    output logic [$clog2(Q_DEPTH):0]     occupancy,
    output logic                         loading
);

    localparam int CNT_W     = $clog2(Q_DEPTH) + 1;
    localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
    logic [ADDR_WIDTH-1:0]   load_cnt_reg, load_cnt_next;
    logic [CNT_W-1:0]        count_reg, count_next;

    logic [INST_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [INST_WIDTH-1:0]   fetch_inst;

    logic [INST_WIDTH-1:0]   q_inst_reg [Q_DEPTH];
    logic [ADDR_WIDTH-1:0]   q_pc_reg   [Q_DEPTH];
    logic [INST_WIDTH-1:0]   q_inst_next [Q_DEPTH];
    logic [ADDR_WIDTH-1:0]   q_pc_next   [Q_DEPTH];

    logic in_run;
    logic in_load;
    logic mem_we;
    logic pop;
    logic push;
    logic full;
    logic clear_q;

    assign in_run     = (state_reg == ST_RUN);
    assign in_load    = (state_reg == ST_LOAD);
    assign mem_we     = in_load && load_valid;
    assign fetch_inst = mem[pc_reg];

    assign out_valid  = (count_reg != '0);
    assign occupancy  = count_reg;
    assign out_inst   = q_inst_reg[0];
    assign out_pc     = q_pc_reg[0];
    assign loading    = in_load;

    // State register, fetch pc, load counter and queue fill level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_RUN;
            pc_reg       <= '0;
            load_cnt_reg <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            load_cnt_reg <= load_cnt_next;
            count_reg    <= count_next;
        end
    end

    // Mode transitions: load_start always wins, load_done returns to RUN
    always_comb begin
        state_next = state_reg;
        if (load_start) begin
            state_next = ST_LOAD;
        end else if (in_load && load_done) begin
            state_next = ST_RUN;
        end
    end

    // Queue control: flushes suppress the push; a pop in a flush cycle still counts
    always_comb begin
        full    = (count_reg == CNT_W'(Q_DEPTH));
        pop     = out_valid && out_ready;
        clear_q = load_start || in_load ||
                  (in_run && (mispredict || redirect_valid));
        push    = in_run && !load_start && !mispredict && !redirect_valid &&
                  (!full || pop);

        count_next = count_reg;
        if (clear_q) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Fetch pc: load_done restarts at 0, mispredict beats redirect, else advance on push
    always_comb begin
        pc_next = pc_reg;
        if (in_load) begin
            if (load_done) begin
                pc_next = '0;
            end
        end else if (mispredict) begin
            pc_next = mispredict_addr;
        end else if (redirect_valid) begin
            pc_next = redirect_addr;
        end else if (push) begin
            pc_next = pc_reg + ADDR_WIDTH'(1);
        end
    end

    // Load address counter, restarted by every load_start
    always_comb begin
        load_cnt_next = load_cnt_reg;
        if (load_start) begin
            load_cnt_next = '0;
        end else if (mem_we) begin
            load_cnt_next = load_cnt_reg + ADDR_WIDTH'(1);
        end
    end

    // Instruction memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_cnt_reg] <= load_data;
        end
    end

    // Shift-style queue: entry 0 is the head, a pop moves every entry down one slot
    generate
        for (genvar gi = 0; gi < Q_DEPTH; gi++) begin : g_entry
            logic [INST_WIDTH-1:0] shift_inst;
            logic [ADDR_WIDTH-1:0] shift_pc;

            if (gi < Q_DEPTH - 1) begin : g_mid
                assign shift_inst = q_inst_reg[gi+1];
                assign shift_pc   = q_pc_reg[gi+1];
            end else begin : g_last
                assign shift_inst = q_inst_reg[gi];
                assign shift_pc   = q_pc_reg[gi];
            end

            // Select the next contents of this entry: shifted, newly fetched, or held
            always_comb begin
                q_inst_next[gi] = q_inst_reg[gi];
                q_pc_next[gi]   = q_pc_reg[gi];
                if (pop) begin
                    if (push && (count_reg - CNT_W'(1) == CNT_W'(gi))) begin
                        q_inst_next[gi] = fetch_inst;
                        q_pc_next[gi]   = pc_reg;
                    end else begin
                        q_inst_next[gi] = shift_inst;
                        q_pc_next[gi]   = shift_pc;
                    end
                end else if (push && (count_reg == CNT_W'(gi))) begin
                    q_inst_next[gi] = fetch_inst;
                    q_pc_next[gi]   = pc_reg;
                end
            end

            // Entry storage, cleared on reset so the head reads zero
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    q_inst_reg[gi] <= '0;
                    q_pc_reg[gi]   <= '0;
                end else begin
                    q_inst_reg[gi] <= q_inst_next[gi];
                    q_pc_reg[gi]   <= q_pc_next[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_inst_fetch_q.sv
// Directed testbench for inst_fetch_q: load, backpressure, redirect,
// priority, address wrap and mid-stream reset.
module tb_inst_fetch_q;

    localparam int INST_WIDTH = 32;
    localparam int ADDR_WIDTH = 14;
    localparam int Q_DEPTH    = 4;
    localparam int N_LOAD     = 272;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      load_start;
    logic                      load_valid;
    logic [INST_WIDTH-1:0]     load_data;
    logic                      load_done;
    logic                      redirect_valid;
    logic [ADDR_WIDTH-1:0]     redirect_addr;
    logic                      mispredict;
    logic [ADDR_WIDTH-1:0]     mispredict_addr;
    logic                      out_valid;
    logic                      out_ready;
    logic [INST_WIDTH-1:0]     out_inst;
    logic [ADDR_WIDTH-1:0]     out_pc;
    logic [$clog2(Q_DEPTH):0]  occupancy;
    logic                      loading;

    int total = 0;
    int bad   = 0;

    inst_fetch_q #(
        .INST_WIDTH (INST_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .Q_DEPTH    (Q_DEPTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .load_start      (load_start),
        .load_valid      (load_valid),
        .load_data       (load_data),
        .load_done       (load_done),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .mispredict      (mispredict),
        .mispredict_addr (mispredict_addr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .occupancy       (occupancy),
        .loading         (loading)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        load_start      = 1'b0;
        load_valid      = 1'b0;
        load_data       = '0;
        load_done       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_addr   = '0;
        mispredict      = 1'b0;
        mispredict_addr = '0;
        out_ready       = 1'b0;

        // Reset state
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_occ",   32'(occupancy), 32'd0);
        check("rst_load",  32'(loading),   32'd0);
        check("rst_pc",    32'(out_pc),    32'd0);
        check("rst_inst",  out_inst,       32'd0);

        // Enter LOAD right after reset release
        reset_n    = 1'b1;
        load_start = 1'b1;
        out_ready  = 1'b1;
        step();
        load_start = 1'b0;
        check("load_mode", 32'(loading),   32'd1);
        check("load_occ",  32'(occupancy), 32'd0);

        // Load words 0xA0+i; redirect/mispredict during LOAD are ignored;
        // the last word shares its cycle with load_done
        for (int i = 0; i < N_LOAD; i++) begin
            load_valid     = 1'b1;
            load_data      = 32'hA0 + 32'(i);
            load_done      = (i == N_LOAD - 1);
            redirect_valid = (i == 5);
            mispredict     = (i == 5);
            redirect_addr  = 14'h55;
            mispredict_addr = 14'h66;
            step();
            if (i == 5) begin
                check("load_ign_occ",   32'(occupancy), 32'd0);
                check("load_ign_valid", 32'(out_valid), 32'd0);
            end
        end
        load_valid     = 1'b0;
        load_done      = 1'b0;
        redirect_valid = 1'b0;
        mispredict     = 1'b0;
        check("done_mode",  32'(loading),   32'd0);
        check("done_valid", 32'(out_valid), 32'd0);

        // Program streams from address 0
        step();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("prog_pc%0d", k),   32'(out_pc), 32'(k));
            check($sformatf("prog_inst%0d", k), out_inst,    32'hA0 + 32'(k));
            if (k < 3) step();
        end

        // Backpressure: restart at 0 with out_ready low
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 14'h0;
        step();
        redirect_valid = 1'b0;
        check("bp_flush_occ", 32'(occupancy), 32'd0);
        for (int c = 0; c < 10; c++) step();
        check("bp_sat_occ",   32'(occupancy), 32'(Q_DEPTH));
        check("bp_sat_valid", 32'(out_valid), 32'd1);
        check("bp_sat_pc",    32'(out_pc),    32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("bp_pc%0d", k),   32'(out_pc),    32'(k));
            check($sformatf("bp_inst%0d", k), out_inst,       32'hA0 + 32'(k));
            check($sformatf("bp_occ%0d", k),  32'(occupancy), 32'(Q_DEPTH));
            step();
        end

        // Build occupancy 3 after a mispredict to 0x30
        out_ready       = 1'b0;
        mispredict      = 1'b1;
        mispredict_addr = 14'h30;
        step();
        mispredict = 1'b0;
        step();
        step();
        step();
        check("mp_occ3",  32'(occupancy), 32'd3);
        check("mp_pc",    32'(out_pc),    32'h30);
        check("mp_inst",  out_inst,       32'hD0);

        // Redirect to 0x100 with a pop in the same cycle
        redirect_valid = 1'b1;
        redirect_addr  = 14'h100;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("rd_occ",    32'(occupancy), 32'd0);
        check("rd_valid",  32'(out_valid), 32'd0);
        step();
        check("rd_valid2", 32'(out_valid), 32'd1);
        check("rd_pc0",    32'(out_pc),    32'h100);
        check("rd_inst0",  out_inst,       32'h1A0);
        step();
        check("rd_pc1",    32'(out_pc),    32'h101);
        check("rd_inst1",  out_inst,       32'h1A1);

        // Mispredict beats redirect in the same cycle
        mispredict      = 1'b1;
        mispredict_addr = 14'h20;
        redirect_valid  = 1'b1;
        redirect_addr   = 14'h40;
        step();
        mispredict     = 1'b0;
        redirect_valid = 1'b0;
        check("pri_occ",   32'(occupancy), 32'd0);
        step();
        check("pri_pc",    32'(out_pc),    32'h20);
        check("pri_inst",  out_inst,       32'hC0);
        step();
        check("pri_pc1",   32'(out_pc),    32'h21);

        // Address wrap from the top of memory to 0
        redirect_valid = 1'b1;
        redirect_addr  = 14'h3FFF;
        step();
        redirect_valid = 1'b0;
        step();
        check("wrap_top",  32'(out_pc),    32'h3FFF);
        step();
        check("wrap_pc0",  32'(out_pc),    32'd0);
        check("wrap_inst", out_inst,       32'hA0);
        step();
        check("wrap_pc1",  32'(out_pc),    32'd1);

        // Asynchronous reset mid-stream, then restart at 0
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_occ",   32'(occupancy), 32'd0);
        check("arst_pc",    32'(out_pc),    32'd0);
        check("arst_inst",  out_inst,       32'd0);
        step();
        reset_n = 1'b1;
        check("rel_valid",  32'(out_valid), 32'd0);
        step();
        check("rel_valid2", 32'(out_valid), 32'd1);
        check("rel_pc0",    32'(out_pc),    32'd0);
        check("rel_inst0",  out_inst,       32'hA0);
        step();
        check("rel_pc1",    32'(out_pc),    32'd1);
        check("rel_inst1",  out_inst,       32'hA1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_q.md
INST_FETCH_Q -- requirements
Module: inst_fetch_q

Interface
Parameters:
REQ-001 SHALL have parameter INST_WIDTH, default 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, instruction memory address width; depth is 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter Q_DEPTH, default 4, fetch-queue entries; power of two, at least 2.

Ports:
REQ-004 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port load_start, input, 1: enter LOAD, clear load counter.
REQ-007 SHALL have port load_valid, input, 1: load_data is valid this cycle (LOAD only).
REQ-008 SHALL have port load_data, input, INST_WIDTH: word to store.
REQ-009 SHALL have port load_done, input, 1: leave LOAD and start fetching at address 0.
REQ-010 SHALL have port redirect_valid, input, 1: predicted-taken jump, branch or jr target.
REQ-011 SHALL have port redirect_addr, input, ADDR_WIDTH: redirect target.
REQ-012 SHALL have port mispredict, input, 1: flush and refetch from the recovery address.
REQ-013 SHALL have port mispredict_addr, input, ADDR_WIDTH: recovery address.
REQ-014 SHALL have port out_valid, output, 1: queue head is valid.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts the head.
REQ-016 SHALL have port out_inst, output, INST_WIDTH: head instruction.
REQ-017 SHALL have port out_pc, output, ADDR_WIDTH: head instruction address.
REQ-018 SHALL have port occupancy, output, $clog2(Q_DEPTH)+1: number of valid queue entries.
REQ-019 SHALL have port loading, output, 1: high while in LOAD.

Function
REQ-020 SHALL implement states RUN and LOAD; load_start in any state moves to LOAD next edge; load_done in LOAD moves to RUN.
REQ-021 SHALL, in LOAD with load_valid, write load_data to mem[load_cnt] and increment load_cnt modulo 2**ADDR_WIDTH.
REQ-022 SHALL, on the load_done edge, set fetch pc to 0 and empty the queue; a load_valid in that same cycle is still written.
REQ-023 SHALL keep the queue empty and out_valid at 0 throughout LOAD; redirect_valid and mispredict are ignored in LOAD.
REQ-024 SHALL use an asynchronous-read memory; in RUN, a push of {pc, mem[pc]} occurs when the queue is not full or a pop happens in the same cycle; pc then increments modulo 2**ADDR_WIDTH.
REQ-025 SHALL pop the head when out_valid and out_ready are both high; out_inst and out_pc are registered queue-head contents.
REQ-026 SHALL, on mispredict, empty the queue and set pc to mispredict_addr; no push occurs that cycle.
REQ-027 SHALL, on redirect_valid without mispredict, empty the queue and set pc to redirect_addr; no push occurs that cycle.
REQ-028 SHALL give mispredict priority over redirect_valid when both are asserted.
REQ-029 SHALL begin pushing from the new pc on the cycle after a flush, so the target appears at out_valid two edges after the flush edge.
REQ-030 SHALL deliver, without flush or backpressure, one instruction per cycle in increasing address order, wrapping from 2**ADDR_WIDTH-1 to 0.
REQ-031 SHALL keep occupancy within 0..Q_DEPTH; out_valid is 1 exactly when occupancy > 0.
REQ-032 SHALL make a pop in a flush cycle complete for the consumer; entries remaining after the flush are discarded.

Reset
REQ-033 SHALL, on reset_n low, asynchronously set state RUN, pc 0, load_cnt 0, queue empty, out_valid 0, occupancy 0, loading 0, out_inst 0, out_pc 0; memory contents are not reset.
REQ-034 SHALL, on reset_n deassertion, begin fetching from address 0 on the first following edge.

Verification
REQ-035 SHALL cover program load: load_start, then words 0xA0..0xA3, then load_done, out_ready=1 -> out_pc 0,1,2,3 with out_inst 0xA0..0xA3 on consecutive cycles.
REQ-036 SHALL cover backpressure: out_ready=0 for 10 cycles -> occupancy saturates at Q_DEPTH, head stays pc 0; out_ready=1 -> pcs 0..Q_DEPTH-1 in order, then continuous.
REQ-037 SHALL cover redirect: redirect_valid with redirect_addr=0x100 while occupancy=3 -> queue emptied, next out_pc 0x100, then 0x101.
REQ-038 SHALL cover priority: mispredict with mispredict_addr=0x20 and redirect_valid with redirect_addr=0x40 in the same cycle -> next out_pc 0x20.
REQ-039 SHALL cover wrap and reset: redirect to 2**ADDR_WIDTH-1 -> out_pc then 0; asserting reset_n low mid-stream -> out_valid 0 immediately; after release, out_pc restarts at 0.
